light_level_seq: RTL and testbench

LIGHT_LEVEL_SEQ -- requirements
Module: light_level_seq

---
 rtl/light_level_seq.sv | 134 +++++++++++++
 tb/tb_light_level_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/light_level_seq.sv
// Steps a 4-level light toward a requested level by issuing paced btn_up/btn_down pulses.
// Optional auto-off (macro LIGHT_AUTO_OFF_EN) walks the light down to 0 after TIMEOUT idle cycles.
module light_level_seq #(
  parameter int STEP_GAP = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       man_up,
  input  logic       man_down,
  input  logic       tgt_valid,
  input  logic [1:0] tgt_level,
  output logic       tgt_ready,
  output logic       step_up,
  output logic       step_down,
  output logic [1:0] level,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  if (STEP_GAP < 1 || STEP_GAP > 255 || TIMEOUT < 1) begin : g_param_check
    $error("light_level_seq: STEP_GAP or TIMEOUT out of range");
  end

  logic [1:0] state, state_nxt;
  logic [1:0] target, target_nxt;
  logic [1:0] level_nxt, goal;
  logic [7:0] gap_cnt, gap_nxt;
  logic       up_nxt, down_nxt, start;
  logic       man_pulse, accept, fire;

  // Pressing both buttons at once cancels out and is treated as no pulse at all.
  assign man_pulse = man_up ^ man_down;
  assign tgt_ready = (state == IDLE) && !man_pulse && !fire && !reset;
  assign accept    = tgt_valid && tgt_ready;
  assign busy      = (state != IDLE);

`ifdef LIGHT_AUTO_OFF_EN
  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;

  assign fire = (state == IDLE) && !man_pulse && (level != 2'd0) &&
                (idle_cnt == IW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (state != IDLE || man_pulse || accept || fire || level == 2'd0)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign fire = 1'b0;
`endif

  // A manual pulse always wins: it is forwarded and any running sequence is dropped.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    gap_nxt    = gap_cnt;
    goal       = target;
    start      = 1'b0;
    up_nxt     = 1'b0;
    down_nxt   = 1'b0;
    if (man_pulse) begin
      state_nxt = IDLE;
      gap_nxt   = 8'd0;
      up_nxt    = man_up;
      down_nxt  = man_down;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            target_nxt = 2'd0;
            goal       = 2'd0;
            start      = 1'b1;
          end else if (accept) begin
            target_nxt = tgt_level;
            goal       = tgt_level;
            start      = (tgt_level != level);
          end
        end
        STEP: begin
          state_nxt = GAP;
          gap_nxt   = 8'(STEP_GAP - 1);
        end
        GAP: begin
          if (gap_cnt <= 8'd1) begin
            gap_nxt = 8'd0;
            if (level == target) state_nxt = IDLE;
            else                 start     = 1'b1;
          end else begin
            gap_nxt = gap_cnt - 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (start) begin
        state_nxt = STEP;
        up_nxt    = (goal > level);
        down_nxt  = (goal < level);
      end
    end
  end

  always_comb begin
    level_nxt = level;
    if (up_nxt && level != 2'd3)        level_nxt = level + 2'd1;
    else if (down_nxt && level != 2'd0) level_nxt = level - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      target    <= 2'd0;
      level     <= 2'd0;
      gap_cnt   <= 8'd0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      level     <= level_nxt;
      gap_cnt   <= gap_nxt;
      step_up   <= up_nxt;
      step_down <= down_nxt;
    end
  end

endmodule

// File: tb/tb_light_level_seq.sv
// Bench for light_level_seq: directed vector table, corner-case sequences and a
// randomized run checked against a pulse-schedule model of the sequencer.
module tb_light_level_seq;

  localparam int STEP_GAP = 4;
  localparam int TIMEOUT  = 20;
  localparam int PERIOD   = (STEP_GAP < 2) ? 2 : STEP_GAP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       man_up = 1'b0, man_down = 1'b0, tgt_valid = 1'b0;
  logic [1:0] tgt_level = 2'd0;
  logic       tgt_ready, step_up, step_down, busy;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;

  light_level_seq #(.STEP_GAP(STEP_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .man_up(man_up), .man_down(man_down),
    .tgt_valid(tgt_valid), .tgt_level(tgt_level), .tgt_ready(tgt_ready),
    .step_up(step_up), .step_down(step_down), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mu, md, tv;
    logic [1:0] tl;
    logic rdy, up, dn;
    logic [1:0] lvl;
    logic bsy;
  } vec_t;

  // Model: a running sequence emits a pulse every PERIOD cycles; rem counts cycles left in the period.
  int m_level, m_target, m_rem, m_idle;
  bit m_active, e_up, e_dn;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_target = 0; m_rem = 0; m_idle = 0;
    m_active = 0; e_up = 0; e_dn = 0;
  endtask

  function automatic bit model_fire(input bit man);
`ifdef LIGHT_AUTO_OFF_EN
    return !m_active && !man && m_level != 0 && m_idle == TIMEOUT - 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_ready(input bit mu, input bit md);
    bit man = mu ^ md;
    return !m_active && !man && !model_fire(man);
  endfunction

  task automatic model_start(input int goal);
    e_up = (goal > m_level);
    e_dn = (goal < m_level);
    m_level = m_level + (e_up ? 1 : -1);
    m_active = 1;
    m_rem = PERIOD - 1;
  endtask

  task automatic model_advance(input bit mu, input bit md, input bit tv, input int tl);
    bit man  = mu ^ md;
    bit fire = model_fire(man);
    bit rdy  = model_ready(mu, md);
    e_up = 0; e_dn = 0;
    if (man) begin
      e_up = mu; e_dn = md;
      if (mu && m_level < 3) m_level++;
      if (md && m_level > 0) m_level--;
      m_active = 0; m_idle = 0;
    end else if (!m_active) begin
      if (fire) begin
        m_target = 0; m_idle = 0;
        model_start(0);
      end else if (tv && rdy) begin
        m_target = tl; m_idle = 0;
        if (tl != m_level) model_start(tl);
      end else begin
        m_idle = (m_level != 0) ? m_idle + 1 : 0;
      end
    end else begin
      m_idle = 0;
      if (m_rem == 0) begin
        if (m_level != m_target) model_start(m_target);
        else m_active = 0;
      end else begin
        m_rem--;
      end
    end
  endtask

  task automatic check_output();
    check("step_up", int'(step_up), int'(e_up));
    check("step_down", int'(step_down), int'(e_dn));
    check("level", int'(level), m_level);
    check("busy", int'(busy), int'(m_active));
  endtask

  // Called just after a rising edge; returns with outputs of the next cycle checked.
  task automatic apply_stimulus(input logic mu, input logic md, input logic tv,
                                input logic [1:0] tl, output logic rdy);
    man_up = mu; man_down = md; tgt_valid = tv; tgt_level = tl;
    @(negedge clk);
    rdy = tgt_ready;
    check("tgt_ready", int'(tgt_ready), int'(model_ready(mu, md)));
    model_advance(mu, md, tv, int'(tl));
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_step_up"}, int'(step_up), 0);
    check({tag, "_step_down"}, int'(step_down), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_tgt_ready"}, int'(tgt_ready), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    man_up = 0; man_down = 0; tgt_valid = 0; tgt_level = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input int mu, md, tv, tl, rdy, up, dn, lvl, bsy);
    vec_t v;
    v.mu = mu[0]; v.md = md[0]; v.tv = tv[0]; v.tl = tl[1:0];
    v.rdy = rdy[0]; v.up = up[0]; v.dn = dn[0]; v.lvl = lvl[1:0]; v.bsy = bsy[0];
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    logic r;
    int n_up, n_dn;

    vecs.push_back(mk(0,0,1,3, 1,1,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,1,1));
    vecs.push_back(mk(0,0,1,0, 0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0, 0,1,0,2,1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 0,0,0,2,1));
    vecs.push_back(mk(0,0,0,0, 0,1,0,3,1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 0,0,0,3,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,3,0));
    vecs.push_back(mk(0,0,1,3, 1,0,0,3,0));
    vecs.push_back(mk(0,1,0,0, 0,0,1,2,0));
    vecs.push_back(mk(1,1,0,0, 1,0,0,2,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,2,0));
    vecs.push_back(mk(1,0,0,0, 0,1,0,3,0));
    vecs.push_back(mk(1,0,0,0, 0,1,0,3,0));
    vecs.push_back(mk(0,0,1,1, 1,0,1,2,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,2,1));
    vecs.push_back(mk(1,0,0,0, 0,1,0,3,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,3,0));
    vecs.push_back(mk(0,0,1,0, 1,0,1,2,1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 0,0,0,2,1));
    vecs.push_back(mk(0,1,0,0, 0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0, 1,0,0,1,0));

    do_reset();

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].mu, vecs[i].md, vecs[i].tv, vecs[i].tl, r);
      check($sformatf("vec%0d_ready", i), int'(r), int'(vecs[i].rdy));
      check($sformatf("vec%0d_up", i), int'(step_up), int'(vecs[i].up));
      check($sformatf("vec%0d_down", i), int'(step_down), int'(vecs[i].dn));
      check($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].lvl));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bsy));
    end

    // Manual step-down right after the first sequencer pulse aborts the climb.
    do_reset();
    apply_stimulus(0, 0, 1, 2'd3, r);
    check("abort_first_up", int'(step_up), 1);
    apply_stimulus(0, 0, 0, 2'd0, r);
    apply_stimulus(0, 1, 0, 2'd0, r);
    check("abort_down", int'(step_down), 1);
    check("abort_busy", int'(busy), 0);
    n_up = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(0, 0, 0, 2'd0, r);
      n_up += int'(step_up);
    end
    check("abort_no_more_up", n_up, 0);
    check("abort_level", int'(level), 0);

    // Asynchronous reset in the middle of a gap.
    apply_stimulus(0, 0, 1, 2'd3, r);
    apply_stimulus(0, 0, 0, 2'd0, r);
    apply_stimulus(0, 0, 0, 2'd0, r);
    check("pre_reset_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check_zero("midgap_reset");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("held_reset");
    reset = 1'b0;
    n_up = 0; n_dn = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(0, 0, 0, 2'd0, r);
      n_up += int'(step_up);
      n_dn += int'(step_down);
    end
    check("post_reset_pulses", n_up + n_dn, 0);

    // Sit idle at level 2 long enough for the auto-off timeout.
    apply_stimulus(0, 0, 1, 2'd2, r);
    n_dn = 0;
    for (int i = 0; i < 50; i++) begin
      apply_stimulus(0, 0, 0, 2'd0, r);
      n_dn += int'(step_down);
    end
`ifdef LIGHT_AUTO_OFF_EN
    check("autooff_down_pulses", n_dn, 2);
    check("autooff_level", int'(level), 0);
`else
    check("autooff_down_pulses", n_dn, 0);
    check("autooff_level", int'(level), 2);
`endif

    for (int i = 0; i < 3000; i++) begin
      int tv_odds = (i < 1500) ? 3 : 40;
      apply_stimulus($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, tv_odds) == 0, 2'($urandom_range(0, 3)), r);
      check("one_hot_pulse", int'(step_up && step_down), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
